keypad_entry: RTL and testbench

Decimal input front-end for the MY8CPU board, and the input-side counterpart of the 7-seg output path. It scans a 4x4 matrix keypad, debounces key presses, and collects up to 3 decimal digits. It converts them BCD-to-binary, the inverse of Bin_to_BCD, and presents an 8-bit value to the CPU IN bus. DIGITS echoes the entry buffer so controller_7seg can display it while the user types.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 rtl/keypad_entry.sv | 90 +++++++++
 tb/tb_keypad_entry.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad decimal-entry path.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [2:0] {
        KF_DIGIT,
        KF_ENTER,
        KF_CLEAR,
        KF_BACK,
        KF_NONE
    } key_func_t;

    typedef struct packed {
        key_func_t  func;
        logic [3:0] digit;
    } key_map_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    localparam int MAX_DIGITS = 3;

    // Indexed by key code = 4*row + col.
    // row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: * 0 # D
    localparam key_map_t KEYMAP [16] = '{
        '{KF_DIGIT, 4'd1}, '{KF_DIGIT, 4'd2}, '{KF_DIGIT, 4'd3}, '{KF_NONE,  4'd0},
        '{KF_DIGIT, 4'd4}, '{KF_DIGIT, 4'd5}, '{KF_DIGIT, 4'd6}, '{KF_NONE,  4'd0},
        '{KF_DIGIT, 4'd7}, '{KF_DIGIT, 4'd8}, '{KF_DIGIT, 4'd9}, '{KF_BACK,  4'd0},
        '{KF_CLEAR, 4'd0}, '{KF_DIGIT, 4'd0}, '{KF_ENTER, 4'd0}, '{KF_NONE,  4'd0}
    };

    // Three packed BCD digits {d2,d1,d0} to binary; 999 fits in 10 bits.
    function automatic logic [9:0] bcd3_to_bin(input logic [11:0] bcd);
        return 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Matrix keypad column scanner with ghost rejection and press/release debounce.
// Latency: one key event per debounced press, DEBOUNCE_SCANS full scans after it settles.
// Backpressure: none; key_vld is a one-cycle pulse the consumer must accept.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock_in,
    input  logic       nReset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_vld,
    output logic [3:0] key_code
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       col_idx;
    logic [1:0]       acc_n;      // closed switches seen so far this scan, saturates at 2
    logic [3:0]       acc_code;
    logic             scan_tick;
    logic             scan_done;

    logic [2:0]       samp_n;
    logic [1:0]       samp_row;
    logic [1:0]       base_n;
    logic [3:0]       base_code;
    logic [2:0]       sum_n;
    logic [1:0]       new_n;
    logic [3:0]       new_code;
    logic             res_hit;

    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       code, code_nxt;
    logic             emit;

    assign scan_tick = (div == DIV_W'(SCAN_DIV - 1));
    assign scan_done = scan_tick && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);
    assign cnt_inc   = cnt + 1'b1;

    // Fold the current column's ROW sample into this scan's running result.
    always_comb begin
        samp_n   = '0;
        samp_row = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                samp_n   = samp_n + 3'd1;
                samp_row = 2'(r);
            end
        end
        base_n    = (col_idx == 2'd0) ? 2'd0 : acc_n;
        base_code = (col_idx == 2'd0) ? 4'd0 : acc_code;
        sum_n     = {1'b0, base_n} + samp_n;
        new_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        new_code  = (samp_n != 3'd0) ? {samp_row, col_idx} : base_code;
        res_hit   = (new_n == 2'd1);
    end

    // Divider, column pointer and per-scan accumulator.
    always_ff @(posedge clock_in) begin
        if (!nReset) begin
            div      <= '0;
            col_idx  <= '0;
            acc_n    <= '0;
            acc_code <= '0;
        end else if (scan_tick) begin
            div      <= '0;
            col_idx  <= col_idx + 2'd1;
            acc_n    <= new_n;
            acc_code <= new_code;
        end else begin
            div      <= div + 1'b1;
        end
    end

    // Debounce state register and registered key event.
    always_ff @(posedge clock_in) begin
        if (!nReset) begin
            state    <= IDLE;
            cnt      <= '0;
            code     <= '0;
            key_vld  <= 1'b0;
            key_code <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            code     <= code_nxt;
            key_vld  <= emit;
            key_code <= code_nxt;
        end
    end

    // Debounce next-state: advances once per completed full scan.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code;
        emit      = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (res_hit) begin
                        code_nxt = res_code_sel(new_code);
                        cnt_nxt  = CNT_W'(1);
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_nxt = HELD;
                            emit      = 1'b1;
                        end else begin
                            state_nxt = PRESS_WAIT;
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (res_hit && (new_code == code)) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_nxt = HELD;
                            emit      = 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (!res_hit) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (DEBOUNCE_SCANS <= 1) ? IDLE : RELEASE_WAIT;
                    end
                end
                RELEASE_WAIT: begin
                    if (!res_hit) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        state_nxt = HELD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    function automatic logic [3:0] res_code_sel(input logic [3:0] c);
        return c;
    endfunction

endmodule

// File: rtl/keypad_entry.sv
// Keypad decimal entry: 3-digit BCD buffer with edit keys and commit to an 8-bit value.
// Latency: buffer/VALUE update one cycle after the scanner's key event.
// Backpressure: none; valid/error are one-cycle pulses, VALUE holds between commits.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clock_in,
    input  logic        nReset,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [7:0]  VALUE,
    output logic [11:0] DIGITS,
    output logic        valid,
    output logic        error
);

    logic       key_vld;
    logic [3:0] key_code;
    key_map_t   key_map;
    logic [1:0] count;
    logic [9:0] bin;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clock_in (clock_in),
        .nReset   (nReset),
        .row      (ROW),
        .col      (COL),
        .key_vld  (key_vld),
        .key_code (key_code)
    );

    assign key_map = KEYMAP[key_code];
    assign bin     = bcd3_to_bin(DIGITS);

    // Entry buffer edits and commit; valid/error default low so they pulse.
    always_ff @(posedge clock_in) begin
        if (!nReset) begin
            VALUE  <= '0;
            DIGITS <= '0;
            count  <= '0;
            valid  <= 1'b0;
            error  <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (key_vld) begin
                case (key_map.func)
                    KF_DIGIT: begin
                        if (count < 2'(MAX_DIGITS)) begin
                            DIGITS <= {DIGITS[7:0], key_map.digit};
                            count  <= count + 2'd1;
                        end else begin
                            error  <= 1'b1;
                        end
                    end
                    KF_BACK: begin
                        if (count != 2'd0) begin
                            DIGITS <= {4'd0, DIGITS[11:4]};
                            count  <= count - 2'd1;
                        end
                    end
                    KF_CLEAR: begin
                        DIGITS <= '0;
                        count  <= '0;
                    end
                    KF_ENTER: begin
                        if (count != 2'd0) begin
                            if (bin <= 10'd255) begin
                                VALUE <= bin[7:0];
                                valid <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                            DIGITS <= '0;
                            count  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a keypad matrix model.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_entry;

    logic        clock_in = 1'b0;
    logic        nReset;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [7:0]  VALUE;
    logic [11:0] DIGITS;
    logic        valid;
    logic        error;

    logic [15:0] keys;

    int n_checks  = 0;
    int n_errors  = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int v0;
    int e0;

    keypad_entry #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clock_in (clock_in),
        .nReset   (nReset),
        .ROW      (ROW),
        .COL      (COL),
        .VALUE    (VALUE),
        .DIGITS   (DIGITS),
        .valid    (valid),
        .error    (error)
    );

    always #5 clock_in = ~clock_in;

    // Keypad model: a closed switch pulls its row low while its column is driven low.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !COL[c]) ROW[r] = 1'b0;
            end
        end
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clock_in) begin
        if (valid === 1'b1) valid_cnt++;
        if (error === 1'b1) err_cnt++;
        if (valid === 1'b1 && error === 1'b1) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic press(input int code, input int hold);
        keys       = '0;
        keys[code] = 1'b1;
        tick(hold);
        keys       = '0;
        tick(64);
    endtask

    task automatic key(input int code);
        press(code, 64);
    endtask

    initial begin
        keys   = '0;
        nReset = 1'b0;
        tick(3);
        chk("rst_col",    32'(COL),    32'hE);
        chk("rst_value",  32'(VALUE),  32'h0);
        chk("rst_digits", 32'(DIGITS), 32'h0);
        chk("rst_valid",  32'(valid),  32'h0);
        chk("rst_error",  32'(error),  32'h0);

        nReset = 1'b1;
        tick(3);
        chk("col_walk0", 32'(COL), 32'hE);
        tick(1);
        chk("col_walk1", 32'(COL), 32'hD);
        tick(4);
        chk("col_walk2", 32'(COL), 32'hB);
        tick(4);
        chk("col_walk3", 32'(COL), 32'h7);
        tick(4);
        chk("col_wrap",  32'(COL), 32'hE);

        // Debounce
        key(5);
        chk("press5", 32'(DIGITS), 32'h005);
        press(5, 16);
        chk("short_press", 32'(DIGITS), 32'h005);
        keys = '0; keys[5] = 1'b1; tick(64);
        keys = '0; tick(16);
        keys[5] = 1'b1; tick(64);
        keys = '0; tick(64);
        chk("bounce_one_event", 32'(DIGITS), 32'h055);
        key(12);
        chk("clear_after_bounce", 32'(DIGITS), 32'h000);

        // Commit 255
        v0 = valid_cnt; e0 = err_cnt;
        key(1);
        chk("d_2",   32'(DIGITS), 32'h002);
        key(5);
        chk("d_25",  32'(DIGITS), 32'h025);
        key(5);
        chk("d_255", 32'(DIGITS), 32'h255);
        key(14);
        chk("commit_value",  32'(VALUE),  32'hFF);
        chk("commit_digits", 32'(DIGITS), 32'h000);
        chk("commit_valid",  32'(valid_cnt - v0), 32'd1);
        chk("commit_noerr",  32'(err_cnt - e0),   32'd0);

        // Range error on 256
        v0 = valid_cnt; e0 = err_cnt;
        key(1); key(5); key(6); key(14);
        chk("range_err",     32'(err_cnt - e0),   32'd1);
        chk("range_novalid", 32'(valid_cnt - v0), 32'd0);
        chk("range_value",   32'(VALUE),  32'hFF);
        chk("range_digits",  32'(DIGITS), 32'h000);

        // Fourth digit overflow
        e0 = err_cnt;
        key(0); key(1); key(2);
        chk("d_123", 32'(DIGITS), 32'h123);
        key(4);
        chk("ovf_digits", 32'(DIGITS), 32'h123);
        chk("ovf_err",    32'(err_cnt - e0), 32'd1);

        // Edit keys
        key(12);
        chk("clear_full", 32'(DIGITS), 32'h000);
        key(0); key(1); key(11);
        chk("back", 32'(DIGITS), 32'h001);
        key(12);
        chk("clear", 32'(DIGITS), 32'h000);
        v0 = valid_cnt; e0 = err_cnt;
        key(14);
        chk("empty_enter_valid", 32'(valid_cnt - v0), 32'd0);
        chk("empty_enter_err",   32'(err_cnt - e0),   32'd0);
        chk("empty_enter_value", 32'(VALUE), 32'hFF);

        // Leading zeros
        v0 = valid_cnt;
        key(13); key(13); key(8);
        chk("d_007", 32'(DIGITS), 32'h007);
        key(14);
        chk("commit_007",       32'(VALUE), 32'h07);
        chk("commit_007_valid", 32'(valid_cnt - v0), 32'd1);

        // Ghost rejection
        keys = '0; keys[0] = 1'b1; keys[1] = 1'b1;
        tick(64);
        keys = '0;
        tick(64);
        chk("ghost", 32'(DIGITS), 32'h000);

        // Reset mid-entry
        key(4); key(1);
        chk("d_42", 32'(DIGITS), 32'h042);
        nReset = 1'b0;
        tick(1);
        chk("midrst_digits", 32'(DIGITS), 32'h000);
        chk("midrst_value",  32'(VALUE),  32'h00);
        chk("midrst_col",    32'(COL),    32'hE);
        nReset = 1'b1;
        key(10);
        chk("after_rst", 32'(DIGITS), 32'h009);

        chk("never_both", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
